alarm_scheduler: RTL and testbench
==================================

Name: alarm_scheduler

Overview:
- Multi-slot alarm controller that owns the wall-clock time base and sequences one shared buzzer.
- Keeps hh:mm:ss from a 1 Hz tick strobe and holds NUM_SLOTS programmable alarm times.
- On each minute boundary it picks the lowest-index enabled slot that matches, then runs the ring / snooze / dismiss state machine.
- Sits between the user-input decoder (buttons, debounced to pulses) and the display/buzzer driver.

Parameters:
- NUM_SLOTS, 4, number of alarm slots (2..8)
- RING_TIMEOUT_S, 60, ticks in RING before auto-dismiss
- SNOOZE_MIN, 5, snooze length in minutes (SNOOZE_MIN*60 ticks)
- MAX_SNOOZE, 3, snoozes allowed per alarm event

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- tick  in  1  1 Hz one-cycle strobe
- time_wr  in  1  load current time
- time_hr  in  8  hour to load (binary, 0..23)
- time_min  in  8  minute to load (0..59)
- slot_wr  in  1  write one alarm slot
- slot_idx  in  clog2(NUM_SLOTS)  slot to write
- slot_hr  in  8  alarm hour
- slot_min  in  8  alarm minute
- slot_en  in  1  slot enable value to write
- snooze  in  1  snooze request pulse
- dismiss  in  1  dismiss request pulse
- cur_hr  out  8  current hour
- cur_min  out  8  current minute
- cur_sec  out  8  current second
- buzzer  out  1  buzzer drive
- ringing  out  1  FSM is in RING or SNOOZE
- active_slot  out  clog2(NUM_SLOTS)  slot that caused the current event
- wr_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset: cur time 00:00:00; all slots 00:00 and disabled; FSM IDLE; buzzer=0; ringing=0; active_slot=0; wr_err=0; all counters 0.
- Time base:
  - On tick, sec increments; 59 wraps to 0 and carries into min.
  - min 59 wraps to 0 and carries into hr; hr 23 wraps to 0.
  - Outputs update on the edge that samples tick.
- time_wr:
  - Loads hr/min and sets sec=0 at the same edge.
  - A tick in the same cycle is discarded.
  - A load never generates a match.
  - hr>23 or min>59: no load; wr_err=1 on the next cycle.
- slot_wr:
  - Stores hr/min/en into slot_idx.
  - hr>23, min>59 or slot_idx>=NUM_SLOTS: rejected with wr_err; the slot is unchanged.
  - Writing the slot that is currently ringing does not affect the FSM.
- Match:
  - A registered minute_strobe is high for one cycle after any tick-driven rollover to sec=0.
  - While minute_strobe=1, compare cur_hr:cur_min against every enabled slot.
  - The lowest matching index wins.
  - Matches are evaluated only in IDLE. In RING or SNOOZE they are dropped, not queued.
- Latency: tick sampled at edge N (time becomes hh:mm:00) -> buzzer=1 after edge N+1.
- FSM states: IDLE, RING, SNOOZE.
  - IDLE -> RING on a match: latch active_slot; clear ring_cnt; clear snooze_used.
  - RING: buzzer=1; ring_cnt increments per tick.
    - dismiss -> IDLE.
    - snooze with snooze_used<MAX_SNOOZE -> SNOOZE: load snz_cnt=SNOOZE_MIN*60; snooze_used++.
    - snooze with snooze_used==MAX_SNOOZE: ignored, keeps ringing.
    - ring_cnt reaching RING_TIMEOUT_S -> IDLE (auto-dismiss).
  - SNOOZE: buzzer=0; snz_cnt decrements per tick.
    - snz_cnt reaching 0 -> RING with ring_cnt cleared.
    - dismiss -> IDLE.
    - snooze ignored.
- Simultaneous events:
  - dismiss and snooze in the same cycle: dismiss wins.
  - dismiss and timeout in the same cycle: IDLE.
  - dismiss or snooze in IDLE: no effect.
- ringing = (state != IDLE). buzzer is registered.
- rst asserted mid-ring: next cycle is the full reset state.

Decomposition:
- Package alarm_pkg:
  - state enum {IDLE, RING, SNOOZE}
  - constants HR_MAX=23, MIN_MAX=59, SEC_MAX=59
  - slot record type {hr[7:0], min[7:0], en}
- Sub-module time_base: hh:mm:ss counter with tick, synchronous load, and minute_strobe output.
- The top holds the slot array, the match priority encoder and the FSM.

Test Plan:
1. Assert rst with random inputs -> cur 00:00:00, buzzer=0, ringing=0, wr_err=0; slot_en=1 at 00:00 then a rollover to 00:00 does not fire until written.
2. time_wr 05:04; slot0=05:05 enabled; 60 ticks -> cur 05:05:00; buzzer=1 exactly one cycle after the 60th tick edge; active_slot=0. Dismiss -> buzzer=0 next cycle.
3. slot2=07:30 and slot1=07:30 enabled, time 07:29:59, one tick -> active_slot=1. slot3=07:31 while ringing -> no change at 07:31.
4. SNOOZE_MIN=1, ring then snooze -> buzzer=0 for 60 ticks, then 1. After 3 snoozes a 4th snooze is ignored and buzzer stays 1. snooze+dismiss same cycle -> IDLE.
5. No input after a ring -> buzzer drops after 60 ticks. Time 23:59:59 with slot 00:00 enabled, one tick -> cur 00:00:00 and the alarm fires.
6. slot_hr=24, then time_min=60, then time_wr and tick in the same cycle -> wr_err pulses for the two invalid writes, values unchanged; the valid load wins with sec=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm scheduler: FSM states, wall-clock
// limits, the alarm slot record and a time-range check used on every write.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RING,
    ST_SNOOZE
  } state_e;

  localparam logic [7:0] HR_MAX  = 8'd23;
  localparam logic [7:0] MIN_MAX = 8'd59;
  localparam logic [7:0] SEC_MAX = 8'd59;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] min;
    logic       en;
  } slot_t;

  // True when hr:mn is a legal time of day.
  function automatic logic time_ok(input logic [7:0] hr, input logic [7:0] mn);
    return (hr <= HR_MAX) && (mn <= MIN_MAX);
  endfunction

endpackage

// File: rtl/time_base.sv
// Wall-clock hh:mm:ss counter advanced by a 1 Hz tick. A load replaces
// hh:mm, zeroes the seconds and swallows a coincident tick. minute_strobe
// is a registered one-cycle flag following every tick-driven wrap to sec=0;
// loads never raise it, so a load can never trigger an alarm match.
module time_base
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [7:0] load_hr_i,
  input  logic [7:0] load_min_i,
  output logic [7:0] hr_o,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       minute_strobe_o
);

  logic [7:0] hr_q, hr_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       strobe_q, strobe_d;

  // Next-time computation: load has priority over tick, carries ripple sec->min->hr.
  always_comb begin
    hr_d     = hr_q;
    min_d    = min_q;
    sec_d    = sec_q;
    strobe_d = 1'b0;
    if (load_i) begin
      hr_d  = load_hr_i;
      min_d = load_min_i;
      sec_d = 8'd0;
    end else if (tick_i) begin
      if (sec_q == SEC_MAX) begin
        sec_d    = 8'd0;
        strobe_d = 1'b1;
        if (min_q == MIN_MAX) begin
          min_d = 8'd0;
          hr_d  = (hr_q == HR_MAX) ? 8'd0 : hr_q + 8'd1;
        end else begin
          min_d = min_q + 8'd1;
        end
      end else begin
        sec_d = sec_q + 8'd1;
      end
    end
  end

  // Time and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hr_q     <= 8'd0;
      min_q    <= 8'd0;
      sec_q    <= 8'd0;
      strobe_q <= 1'b0;
    end else begin
      hr_q     <= hr_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      strobe_q <= strobe_d;
    end
  end

  assign hr_o            = hr_q;
  assign min_o           = min_q;
  assign sec_o           = sec_q;
  assign minute_strobe_o = strobe_q;

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: owns the time base, the programmable slot
// table, a lowest-index-wins match encoder and the ring/snooze/dismiss FSM
// that drives one shared buzzer.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZE     = 3,
  localparam int IDX_W         = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             time_wr,
  input  logic [7:0]       time_hr,
  input  logic [7:0]       time_min,
  input  logic             slot_wr,
  input  logic [IDX_W-1:0] slot_idx,
  input  logic [7:0]       slot_hr,
  input  logic [7:0]       slot_min,
  input  logic             slot_en,
  input  logic             snooze,
  input  logic             dismiss,
  output logic [7:0]       cur_hr,
  output logic [7:0]       cur_min,
  output logic [7:0]       cur_sec,
  output logic             buzzer,
  output logic             ringing,
  output logic [IDX_W-1:0] active_slot,
  output logic             wr_err
);

  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);
  localparam int RC_W      = $clog2(RING_TIMEOUT_S + 1);
  localparam int SU_W      = $clog2(MAX_SNOOZE + 1);

  logic             time_ok_w, slot_ok_w, minute_strobe;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  slot_t            slots_q [NUM_SLOTS];
  state_e           state_q, state_d;
  logic [RC_W-1:0]  ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
  logic [SU_W-1:0]  snz_used_q, snz_used_d;
  logic [IDX_W-1:0] active_q, active_d;
  logic             buzzer_q, wr_err_q;

  assign time_ok_w = time_ok(time_hr, time_min);
  assign slot_ok_w = time_ok(slot_hr, slot_min) &&
                     ({1'b0, slot_idx} < (IDX_W + 1)'(NUM_SLOTS));

  time_base u_time_base (
    .clk             (clk),
    .rst             (rst),
    .tick_i          (tick),
    .load_i          (time_wr && time_ok_w),
    .load_hr_i       (time_hr),
    .load_min_i      (time_min),
    .hr_o            (cur_hr),
    .min_o           (cur_min),
    .sec_o           (cur_sec),
    .minute_strobe_o (minute_strobe)
  );

  // Slot table; rejected writes leave every slot untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= '0;
      end
    end else if (slot_wr && slot_ok_w) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (IDX_W'(i) == slot_idx) begin
          slots_q[i].hr  <= slot_hr;
          slots_q[i].min <= slot_min;
          slots_q[i].en  <= slot_en;
        end
      end
    end
  end

  // Priority encoder: scanning from the top lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slots_q[i].en && slots_q[i].hr == cur_hr && slots_q[i].min == cur_min) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // FSM next state; dismiss dominates snooze and timeout, matches outside IDLE are dropped.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    snz_used_d = snz_used_q;
    active_d   = active_q;
    case (state_q)
      ST_IDLE: begin
        if (minute_strobe && hit) begin
          state_d    = ST_RING;
          active_d   = hit_idx;
          ring_cnt_d = '0;
          snz_used_d = '0;
        end
      end
      ST_RING: begin
        if (dismiss) begin
          state_d = ST_IDLE;
        end else if (snooze && snz_used_q < SU_W'(MAX_SNOOZE)) begin
          state_d    = ST_SNOOZE;
          snz_cnt_d  = SNZ_W'(SNZ_TICKS);
          snz_used_d = snz_used_q + 1'b1;
        end else if (tick) begin
          if (ring_cnt_q == RC_W'(RING_TIMEOUT_S - 1)) begin
            state_d = ST_IDLE;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (dismiss) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (snz_cnt_q <= SNZ_W'(1)) begin
            state_d    = ST_RING;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
          end else begin
            snz_cnt_d = snz_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, counters, registered buzzer and write-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      snz_used_q <= '0;
      active_q   <= '0;
      buzzer_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      snz_used_q <= snz_used_d;
      active_q   <= active_d;
      buzzer_q   <= (state_d == ST_RING);
      wr_err_q   <= (time_wr && !time_ok_w) || (slot_wr && !slot_ok_w);
    end
  end

  assign buzzer      = buzzer_q;
  assign ringing     = (state_q != ST_IDLE);
  assign active_slot = active_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Testbench for alarm_scheduler: directed scenarios plus a randomized run,
// all checked against a seconds-of-day / tick-timestamp reference model.
module tb_alarm_scheduler;

  localparam int NS = 4;
  localparam int RT = 60;
  localparam int SM = 1;
  localparam int MS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, time_wr = 1'b0, slot_wr = 1'b0, slot_en = 1'b0;
  logic       snooze = 1'b0, dismiss = 1'b0;
  logic [7:0] time_hr = 8'd0, time_min = 8'd0, slot_hr = 8'd0, slot_min = 8'd0;
  logic [1:0] slot_idx = 2'd0;
  logic [7:0] cur_hr, cur_min, cur_sec;
  logic       buzzer, ringing, wr_err;
  logic [1:0] active_slot;

  int passed = 0;
  int total  = 0;

  alarm_scheduler #(
    .NUM_SLOTS(NS), .RING_TIMEOUT_S(RT), .SNOOZE_MIN(SM), .MAX_SNOOZE(MS)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .time_wr(time_wr), .time_hr(time_hr),
    .time_min(time_min), .slot_wr(slot_wr), .slot_idx(slot_idx), .slot_hr(slot_hr),
    .slot_min(slot_min), .slot_en(slot_en), .snooze(snooze), .dismiss(dismiss),
    .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec), .buzzer(buzzer),
    .ringing(ringing), .active_slot(active_slot), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Reference model: time as seconds of day, alarm timing by absolute tick counts.
  int m_tod, m_mode, m_act, m_tc, m_ring_start, m_wake, m_snoozes;
  int m_shr[NS], m_smin[NS];
  bit m_sen[NS];
  bit m_pending, m_err;

  function automatic void model_reset();
    m_tod = 0; m_mode = 0; m_act = 0; m_tc = 0; m_ring_start = 0; m_wake = 0;
    m_snoozes = 0; m_pending = 0; m_err = 0;
    for (int i = 0; i < NS; i++) begin
      m_shr[i] = 0; m_smin[i] = 0; m_sen[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit tval, sval;
    int new_tc, hit;
    if (rst) begin
      model_reset();
      return;
    end
    tval   = (time_hr <= 23) && (time_min <= 59);
    sval   = (slot_hr <= 23) && (slot_min <= 59) && (int'(slot_idx) < NS);
    new_tc = m_tc + int'(tick);
    hit    = -1;
    case (m_mode)
      0: if (m_pending) begin
        for (int i = 0; i < NS; i++)
          if (hit < 0 && m_sen[i] && m_shr[i] == m_tod / 3600 && m_smin[i] == (m_tod / 60) % 60)
            hit = i;
        if (hit >= 0) begin
          m_mode = 1; m_act = hit; m_ring_start = new_tc; m_snoozes = 0;
        end
      end
      1: begin
        if (dismiss) m_mode = 0;
        else if (snooze && m_snoozes < MS) begin
          m_mode = 2; m_snoozes++; m_wake = new_tc + SM * 60;
        end else if (tick && new_tc - m_ring_start >= RT) m_mode = 0;
      end
      default: begin
        if (dismiss) m_mode = 0;
        else if (tick && new_tc == m_wake) begin
          m_mode = 1; m_ring_start = new_tc;
        end
      end
    endcase
    m_pending = 0;
    if (time_wr && tval) m_tod = int'(time_hr) * 3600 + int'(time_min) * 60;
    else if (tick) begin
      m_tod = (m_tod + 1) % 86400;
      m_pending = (m_tod % 60 == 0);
    end
    if (slot_wr && sval) begin
      m_shr[slot_idx] = int'(slot_hr); m_smin[slot_idx] = int'(slot_min); m_sen[slot_idx] = slot_en;
    end
    m_err = (time_wr && !tval) || (slot_wr && !sval);
    m_tc  = new_tc;
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    tick = 0; time_wr = 0; slot_wr = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic set_time(input int h, input int m);
    time_wr = 1; time_hr = 8'(h); time_min = 8'(m);
    cyc();
  endtask

  task automatic set_slot(input int i, input int h, input int m, input bit e);
    slot_wr = 1; slot_idx = 2'(i); slot_hr = 8'(h); slot_min = 8'(m); slot_en = e;
    cyc();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1; cyc(); cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (5) begin
      tick = 1'($urandom); time_wr = 1'($urandom); slot_wr = 1'($urandom);
      snooze = 1'($urandom); dismiss = 1'($urandom);
      time_hr = 8'($urandom_range(0, 30)); time_min = 8'($urandom_range(0, 70));
      cyc();
    end
    total++;
    if ({cur_hr, cur_min, cur_sec} !== 24'd0 || buzzer !== 1'b0 || ringing !== 1'b0 ||
        wr_err !== 1'b0 || active_slot !== 2'd0)
      $display("FAIL reset_state: got %0d:%0d:%0d bz=%b rg=%b err=%b act=%0d want all 0",
               cur_hr, cur_min, cur_sec, buzzer, ringing, wr_err, active_slot);
    else passed++;
    rst = 0;
    set_time(23, 59);
    ticks(59);
    tick = 1; cyc();
    total++;
    if ({cur_hr, cur_min, cur_sec} !== 24'd0)
      $display("FAIL reset_rollover_time: got %0d:%0d:%0d want 0:0:0", cur_hr, cur_min, cur_sec);
    else passed++;
    cyc();
    total++;
    if (buzzer !== 1'b0 || ringing !== 1'b0)
      $display("FAIL reset_slots_disabled: bz=%b rg=%b want 0 0", buzzer, ringing);
    else passed++;
  endtask

  task automatic test_basic();
    set_time(5, 4);
    set_slot(0, 5, 5, 1);
    ticks(59);
    tick = 1; cyc();
    total++;
    if (cur_hr !== 8'd5 || cur_min !== 8'd5 || cur_sec !== 8'd0 || buzzer !== 1'b0)
      $display("FAIL basic_edge_n: got %0d:%0d:%0d bz=%b want 5:5:0 bz=0", cur_hr, cur_min, cur_sec, buzzer);
    else passed++;
    cyc();
    total++;
    if (buzzer !== 1'b1 || ringing !== 1'b1 || active_slot !== 2'd0)
      $display("FAIL basic_fire: bz=%b rg=%b act=%0d want 1 1 0", buzzer, ringing, active_slot);
    else passed++;
    dismiss = 1; cyc();
    total++;
    if (buzzer !== 1'b0 || ringing !== 1'b0)
      $display("FAIL basic_dismiss: bz=%b rg=%b want 0 0", buzzer, ringing);
    else passed++;
  endtask

  task automatic test_priority();
    set_slot(2, 7, 30, 1);
    set_slot(1, 7, 30, 1);
    set_time(7, 29);
    ticks(59);
    tick = 1; cyc(); cyc();
    total++;
    if (buzzer !== 1'b1 || active_slot !== 2'd1)
      $display("FAIL prio_lowest: bz=%b act=%0d want 1 1", buzzer, active_slot);
    else passed++;
    snooze = 1; cyc();
    set_slot(3, 7, 31, 1);
    ticks(60);
    total++;
    if (cur_min !== 8'd31 || buzzer !== 1'b1 || active_slot !== 2'd1)
      $display("FAIL prio_drop_in_ring: min=%0d bz=%b act=%0d want 31 1 1", cur_min, buzzer, active_slot);
    else passed++;
    dismiss = 1; cyc();
    repeat (3) cyc();
    total++;
    if (ringing !== 1'b0)
      $display("FAIL prio_not_queued: rg=%b want 0", ringing);
    else passed++;
  endtask

  task automatic test_snooze();
    set_slot(0, 10, 1, 1);
    set_time(10, 0);
    ticks(59);
    tick = 1; cyc(); cyc();
    total++;
    if (buzzer !== 1'b1)
      $display("FAIL snz_start: bz=%b want 1", buzzer);
    else passed++;
    for (int s = 0; s < MS; s++) begin
      snooze = 1; cyc();
      for (int t = 0; t < 59; t++) begin
        tick = 1; cyc();
        total++;
        if (buzzer !== 1'b0 || ringing !== 1'b1)
          $display("FAIL snz_quiet: snz=%0d t=%0d bz=%b rg=%b want 0 1", s, t, buzzer, ringing);
        else passed++;
        cyc();
      end
      tick = 1; cyc();
      total++;
      if (buzzer !== 1'b1)
        $display("FAIL snz_wake: snz=%0d bz=%b want 1", s, buzzer);
      else passed++;
    end
    snooze = 1; cyc();
    tick = 1; cyc();
    total++;
    if (buzzer !== 1'b1 || ringing !== 1'b1)
      $display("FAIL snz_limit: bz=%b rg=%b want 1 1", buzzer, ringing);
    else passed++;
    snooze = 1; dismiss = 1; cyc();
    total++;
    if (buzzer !== 1'b0 || ringing !== 1'b0)
      $display("FAIL snz_dismiss_wins: bz=%b rg=%b want 0 0", buzzer, ringing);
    else passed++;
  endtask

  task automatic test_timeout();
    set_slot(0, 12, 0, 1);
    set_time(11, 59);
    ticks(59);
    tick = 1; cyc(); cyc();
    ticks(RT - 1);
    total++;
    if (buzzer !== 1'b1)
      $display("FAIL timeout_before: bz=%b want 1", buzzer);
    else passed++;
    tick = 1; cyc();
    total++;
    if (buzzer !== 1'b0 || ringing !== 1'b0)
      $display("FAIL timeout_auto: bz=%b rg=%b want 0 0", buzzer, ringing);
    else passed++;
    set_slot(0, 0, 0, 1);
    set_time(23, 59);
    ticks(59);
    tick = 1; cyc();
    total++;
    if ({cur_hr, cur_min, cur_sec} !== 24'd0)
      $display("FAIL midnight_time: got %0d:%0d:%0d want 0:0:0", cur_hr, cur_min, cur_sec);
    else passed++;
    cyc();
    total++;
    if (buzzer !== 1'b1 || active_slot !== 2'd0)
      $display("FAIL midnight_fire: bz=%b act=%0d want 1 0", buzzer, active_slot);
    else passed++;
    rst = 1; cyc(); rst = 0;
    total++;
    if (buzzer !== 1'b0 || ringing !== 1'b0 || {cur_hr, cur_min, cur_sec} !== 24'd0)
      $display("FAIL midring_reset: bz=%b rg=%b t=%0d:%0d:%0d want 0 0 0:0:0",
               buzzer, ringing, cur_hr, cur_min, cur_sec);
    else passed++;
    set_time(23, 59);
    ticks(60);
    total++;
    if (ringing !== 1'b0)
      $display("FAIL reset_clears_slots: rg=%b want 0", ringing);
    else passed++;
  endtask

  task automatic test_wr_err();
    set_time(8, 15);
    set_slot(2, 24, 0, 1);
    total++;
    if (wr_err !== 1'b1)
      $display("FAIL err_slot_hr: wr_err=%b want 1", wr_err);
    else passed++;
    cyc();
    total++;
    if (wr_err !== 1'b0)
      $display("FAIL err_pulse_width: wr_err=%b want 0", wr_err);
    else passed++;
    set_time(8, 60);
    total++;
    if (wr_err !== 1'b1 || cur_hr !== 8'd8 || cur_min !== 8'd15)
      $display("FAIL err_time_min: wr_err=%b t=%0d:%0d want 1 8:15", wr_err, cur_hr, cur_min);
    else passed++;
    ticks(3);
    time_wr = 1; time_hr = 8'd9; time_min = 8'd10; tick = 1; cyc();
    total++;
    if (cur_hr !== 8'd9 || cur_min !== 8'd10 || cur_sec !== 8'd0 || wr_err !== 1'b0)
      $display("FAIL load_beats_tick: t=%0d:%0d:%0d err=%b want 9:10:0 0",
               cur_hr, cur_min, cur_sec, wr_err);
    else passed++;
  endtask

  task automatic test_random();
    set_time(14, 58);
    for (int c = 0; c < 6000; c++) begin
      int mh, mm;
      mh = m_tod / 3600;
      mm = (m_tod / 60) % 60;
      rst      = ($urandom_range(0, 999) == 0);
      tick     = ($urandom_range(0, 2) == 0);
      time_wr  = ($urandom_range(0, 299) == 0);
      time_hr  = 8'($urandom_range(0, 24));
      time_min = 8'($urandom_range(0, 60));
      slot_wr  = ($urandom_range(0, 59) == 0);
      slot_idx = 2'($urandom_range(0, NS - 1));
      slot_hr  = ($urandom_range(0, 7) == 0) ? 8'd24 : 8'(mh);
      slot_min = ($urandom_range(0, 7) == 0) ? 8'd60 : 8'((mm + $urandom_range(0, 2)) % 60);
      slot_en  = ($urandom_range(0, 3) != 0);
      snooze   = ($urandom_range(0, 39) == 0);
      dismiss  = ($urandom_range(0, 119) == 0);
      cyc();
      rst = 0;
      total++;
      if (int'(cur_hr) != m_tod / 3600 || int'(cur_min) != (m_tod / 60) % 60 ||
          int'(cur_sec) != m_tod % 60 || buzzer !== (m_mode == 1) ||
          ringing !== (m_mode != 0) || wr_err !== m_err ||
          (m_mode != 0 && int'(active_slot) != m_act))
        $display("FAIL random c=%0d: dut %0d:%0d:%0d bz=%b rg=%b err=%b act=%0d model %0d:%0d:%0d mode=%0d err=%b act=%0d",
                 c, cur_hr, cur_min, cur_sec, buzzer, ringing, wr_err, active_slot,
                 m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_mode, m_err, m_act);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_priority();
    test_snooze();
    test_timeout();
    test_wr_err();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
